// File: rtl/nn_dense_argmax_if.sv
// nn_dense_argmax_if: request, SRAM and result signals of the dense argmax engine
interface nn_dense_argmax_if #(
   parameter int N_IN   = 784,
   parameter int W_W    = 16,
   parameter int ACC_W  = 32,
   parameter int ADDR_W = 20,
   parameter int PRED_W = 5
);
   logic              Start;
   logic [N_IN-1:0]   data;
   logic [W_W-1:0]    rdata;
   logic [ADDR_W-1:0] address;
   logic              rd_en;
   logic [PRED_W-1:0] prediction;
   logic [ACC_W-1:0]  max_score;
   logic              resp;
   logic              busy;
   modport master (output Start, data, rdata, input address, rd_en, prediction, max_score, resp, busy);
   modport slave  (input Start, data, rdata, output address, rd_en, prediction, max_score, resp, busy);
endinterface

// File: rtl/nn_dense_argmax.sv
// nn_dense_argmax: streams signed weights from SRAM, scores each neuron over a binary input, reports argmax
module nn_dense_argmax #(
   parameter int N_IN      = 784,
   parameter int N_OUT     = 10,
   parameter int W_W       = 16,
   parameter int ACC_W     = 32,
   parameter int ADDR_W    = 20,
   parameter int BASE_ADDR = 0,
   parameter int RD_LAT    = 2,
   parameter int PRED_W    = 5
) (
   input logic               Clk,
   input logic               Rst_n,
   nn_dense_argmax_if.slave  bus
);
   localparam int I_W = N_IN > 1 ? $clog2(N_IN) : 1;
   localparam int J_W = $clog2(N_OUT);
   if (ACC_W < W_W + $clog2(N_IN + 1)) begin : g_acc_chk
      $error("ACC_W too narrow for N_IN weights of W_W bits");
   end
   if (PRED_W < J_W) begin : g_pred_chk
      $error("PRED_W too narrow for N_OUT classes");
   end
   if (RD_LAT < 1) begin : g_lat_chk
      $error("RD_LAT must be at least 1");
   end
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
   state_t state, state_nxt;
   logic [N_IN-1:0]          data_q;
   logic [I_W-1:0]           i_cnt;
   logic [J_W-1:0]           j_cnt;
   logic [ADDR_W-1:0]        addr_q;
   logic [RD_LAT-1:0]        tag_v;
   logic [I_W-1:0]           tag_i [RD_LAT];
   logic [J_W-1:0]           tag_j [RD_LAT];
   logic signed [ACC_W-1:0]  acc, best, score_q, term;
   logic [J_W-1:0]           best_j, cmp_j;
   logic [PRED_W-1:0]        pred_q;
   logic                     cmp_v, rd, accept, last_issue, take, win, last_cmp;
   assign accept     = state == IDLE && bus.Start;
   assign last_issue = state == FETCH && i_cnt == I_W'(N_IN - 1) && j_cnt == J_W'(N_OUT - 1);
   assign take       = tag_v[RD_LAT-1];
   assign term       = data_q[tag_i[RD_LAT-1]] ? ACC_W'(signed'(bus.rdata)) : '0;
   assign win        = cmp_j == '0 || acc > best;
   assign last_cmp   = cmp_v && cmp_j == J_W'(N_OUT - 1);
   assign bus.address    = addr_q;
   assign bus.prediction = pred_q;
   assign bus.max_score  = score_q;
   // state register
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) state <= IDLE;
      else        state <= state_nxt;
   // next state and per-state strobes
   always_comb begin
      state_nxt  = state;
      rd         = state == FETCH;
      bus.rd_en  = rd;
      bus.resp   = state == DONE;
      bus.busy   = state != IDLE;
      case (state)
         IDLE:    state_nxt = bus.Start ? FETCH : IDLE;
         FETCH:   state_nxt = last_issue ? DRAIN : FETCH;
         DRAIN:   state_nxt = last_cmp ? DONE : DRAIN;
         default: state_nxt = IDLE;
      endcase
   end
   // input capture and j-major/i-minor address walk; address holds after the last issue
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         data_q <= '0;
         i_cnt  <= '0;
         j_cnt  <= '0;
         addr_q <= ADDR_W'(BASE_ADDR);
      end else if (accept) begin
         data_q <= bus.data;
         i_cnt  <= '0;
         j_cnt  <= '0;
         addr_q <= ADDR_W'(BASE_ADDR);
      end else if (state == FETCH && !last_issue) begin
         addr_q <= addr_q + ADDR_W'(1);
         i_cnt  <= i_cnt == I_W'(N_IN - 1) ? '0 : i_cnt + I_W'(1);
         j_cnt  <= i_cnt == I_W'(N_IN - 1) ? j_cnt + J_W'(1) : j_cnt;
      end
   // (j,i) tags travel alongside the SRAM read so the last stage lines up with rdata
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         tag_v <= '0;
         for (int d = 0; d < RD_LAT; d++) begin
            tag_i[d] <= '0;
            tag_j[d] <= '0;
         end
      end else begin
         tag_v[0] <= rd;
         tag_i[0] <= i_cnt;
         tag_j[0] <= j_cnt;
         for (int d = 1; d < RD_LAT; d++) begin
            tag_v[d] <= tag_v[d-1];
            tag_i[d] <= tag_i[d-1];
            tag_j[d] <= tag_j[d-1];
         end
      end
   // accumulate, then compare the finished neuron one cycle later; the final compare lands in the outputs
   always_ff @(posedge Clk or negedge Rst_n)
      if (!Rst_n) begin
         acc     <= '0;
         best    <= '0;
         best_j  <= '0;
         cmp_v   <= 1'b0;
         cmp_j   <= '0;
         pred_q  <= '0;
         score_q <= '0;
      end else begin
         cmp_v <= take && tag_i[RD_LAT-1] == I_W'(N_IN - 1);
         cmp_j <= tag_j[RD_LAT-1];
         if (take) acc <= tag_i[RD_LAT-1] == '0 ? term : acc + term;
         if (cmp_v && win) begin
            best   <= acc;
            best_j <= cmp_j;
         end
         if (last_cmp) begin
            pred_q  <= PRED_W'(win ? cmp_j : best_j);
            score_q <= win ? acc : best;
         end
      end
endmodule

// File: tb/tb_nn_dense_argmax.sv
// tb_nn_dense_argmax: directed runs against a spec-level scoring model with per-cycle output checks
module tb_nn_dense_argmax;
   localparam int N_IN = 4, N_OUT = 3, NM = 12, BASE = 16, LAT_A = 1, LAT_B = 3;
   localparam int LA = NM + LAT_A + 2;
   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   always #5 Clk = ~Clk;
   nn_dense_argmax_if #(.N_IN(4), .W_W(16), .ACC_W(32), .ADDR_W(20), .PRED_W(5)) ia ();
   nn_dense_argmax_if #(.N_IN(4), .W_W(16), .ACC_W(32), .ADDR_W(20), .PRED_W(5)) ib ();
   nn_dense_argmax #(.N_IN(4), .N_OUT(3), .W_W(16), .ACC_W(32), .ADDR_W(20), .BASE_ADDR(BASE),
                     .RD_LAT(LAT_A), .PRED_W(5)) dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ia));
   nn_dense_argmax #(.N_IN(4), .N_OUT(3), .W_W(16), .ACC_W(32), .ADDR_W(20), .BASE_ADDR(BASE),
                     .RD_LAT(LAT_B), .PRED_W(5)) dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ib));
   logic signed [15:0] mem [64];
   logic [15:0] pa;
   logic [15:0] pb [LAT_B];
   int wt [5][12] = '{
      '{1, 1, 1, 1, 2, 2, 2, 2, -1, 0, 0, 0},
      '{5, 0, 5, 0, 0, 9, 0, 9, 3, 0, 3, 0},
      '{2, 2, 0, 0, 4, 0, 0, 0, 1, 3, 0, 0},
      '{100, 100, 100, -7, 100, 100, 100, -3, 100, 100, 100, -32768},
      '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
   // behavioural SRAMs with 1 and 3 cycles of read latency; idle cycles return junk
   always @(posedge Clk) begin
      pa    <= ia.rd_en ? mem[ia.address[5:0]] : 16'h7777;
      pb[0] <= ib.rd_en ? mem[ib.address[5:0]] : 16'h7777;
      for (int d = 1; d < LAT_B; d++) pb[d] <= pb[d-1];
   end
   assign ia.rdata = pa;
   assign ib.rdata = pb[LAT_B-1];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   // model of dut_a: scores computed straight from the weight table at acceptance, timing from cycle count
   bit m_busy;
   int c;
   int s;
   logic [4:0]  m_pred, e_pred;
   logic [31:0] m_max, e_max, m_addr;
   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         m_busy = 0; c = 0; m_pred = 0; m_max = 0; m_addr = BASE;
      end else if (m_busy) begin
         c++;
         if (c == LA - 1) begin m_pred = e_pred; m_max = e_max; end
         if (c == LA) m_busy = 0;
      end else if (ia.Start) begin
         m_busy = 1; c = 0;
         for (int j = 0; j < N_OUT; j++) begin
            s = 0;
            for (int i = 0; i < N_IN; i++) if (ia.data[i]) s += int'(mem[BASE + j*N_IN + i]);
            if (j == 0 || s > $signed(e_max)) begin e_max = s; e_pred = 5'(j); end
         end
      end
      if (m_busy) m_addr = BASE + (c < NM ? c : NM - 1);
   end
   // per-cycle comparison of every dut_a output against the model
   always @(negedge Clk) if (Rst_n) begin
      chk("rd_en", 32'(ia.rd_en), 32'(m_busy && c < NM));
      chk("busy", 32'(ia.busy), 32'(m_busy));
      chk("resp", 32'(ia.resp), 32'(m_busy && c == LA - 1));
      chk("address", 32'(ia.address), m_addr);
      chk("prediction", 32'(ia.prediction), 32'(m_pred));
      chk("max_score", ia.max_score, m_max);
   end
   task automatic load(input int t);
      for (int k = 0; k < NM; k++) mem[BASE + k] = 16'(wt[t][k]);
   endtask
   task automatic run_a(input logic [3:0] d, input int ep, input int em, input string nm);
      int n;
      bit seen;
      @(negedge Clk);
      ia.Start = 1'b1; ia.data = d;
      @(posedge Clk);
      #1 ia.Start = 1'b0; ia.data = ~d;
      n = 0; seen = 0;
      while (!seen && n < 100) begin
         @(negedge Clk);
         n++;
         if (ia.resp) seen = 1;
      end
      chk({nm, "_latency"}, 32'(n), 32'd15);
      chk({nm, "_pred"}, 32'(ia.prediction), 32'(ep));
      chk({nm, "_max"}, ia.max_score, 32'(em));
      @(negedge Clk);
      chk({nm, "_resp_width"}, 32'(ia.resp), 32'd0);
      chk({nm, "_pred_hold"}, 32'(ia.prediction), 32'(ep));
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      int last, n, np;
      ia.Start = 1'b0; ia.data = '0;
      ib.Start = 1'b0; ib.data = '0;
      for (int k = 0; k < 64; k++) mem[k] = 16'h5555;
      repeat (3) @(negedge Clk);
      chk("rst_busy", 32'(ia.busy), 32'd0);
      chk("rst_rd_en", 32'(ia.rd_en), 32'd0);
      chk("rst_address", 32'(ia.address), 32'd16);
      chk("rst_pred", 32'(ia.prediction), 32'd0);
      Rst_n = 1'b1;
      load(0); run_a(4'b1111, 1, 8, "t2");
      load(0); run_a(4'b0000, 0, 0, "zero");
      load(1); run_a(4'b0101, 0, 10, "t3");
      load(2); run_a(4'b0011, 0, 4, "t4_tie");
      load(3); run_a(4'b1000, 1, -3, "t5_neg");
      load(0);
      @(negedge Clk);
      ia.Start = 1'b1; ia.data = 4'b1111;
      @(posedge Clk);
      #1 ia.Start = 1'b0;
      repeat (5) @(negedge Clk);
      #2 Rst_n = 1'b0;
      #1;
      chk("t1_busy", 32'(ia.busy), 32'd0);
      chk("t1_rd_en", 32'(ia.rd_en), 32'd0);
      chk("t1_resp", 32'(ia.resp), 32'd0);
      chk("t1_address", 32'(ia.address), 32'd16);
      chk("t1_pred", 32'(ia.prediction), 32'd0);
      chk("t1_max", ia.max_score, 32'd0);
      @(negedge Clk);
      Rst_n = 1'b1;
      run_a(4'b1111, 1, 8, "t1_rerun");
      @(negedge Clk);
      ib.Start = 1'b1; ib.data = 4'b1111;
      last = 0; n = 0; np = 0;
      while (np < 4 && n < 200) begin
         @(negedge Clk);
         n++;
         if (ib.resp) begin
            if (np == 0) chk("t6_first_latency", 32'(n), 32'd17);
            else chk("t6_period", 32'(n - last), 32'd18);
            chk("t6_pred", 32'(ib.prediction), 32'd1);
            chk("t6_max", ib.max_score, 32'd8);
            last = n; np++;
         end
      end
      chk("t6_pulses", 32'(np), 32'd4);
      ib.Start = 1'b0;
      repeat (25) @(negedge Clk);
      chk("t6_idle", 32'(ib.busy), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
